// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: load-use, redirect, mul/div occupancy, dmem waits.
// Optional performance counters are compiled in when HAZARD_PERF_EN is defined.
module hazard_ctrl #(
  parameter int MULDIV_LAT = 8,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] d_rs1,
  input  logic [REG_ADDR_W-1:0] d_rs2,
  input  logic                  d_rs1_used,
  input  logic                  d_rs2_used,
  input  logic [REG_ADDR_W-1:0] e_rd,
  input  logic                  e_is_load,
  input  logic                  e_muldiv_start,
  input  logic                  e_redirect,
  input  logic                  dmem_req,
  input  logic                  dmem_ready,
  output logic                  stall_pc,
  output logic                  stall_fd,
  output logic                  stall_de,
  output logic                  flush_fd,
  output logic                  flush_de,
  output logic                  muldiv_done
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]           perf_stall_cycles,
  output logic [31:0]           perf_flush_cnt,
  output logic [31:0]           perf_loaduse_cnt
`endif
);

  localparam int CNT_W = $clog2(MULDIV_LAT) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, MEM_WAIT} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             load_use;
  logic             mem_stall;
  logic             loaduse_bubble;

  // x0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign load_use  = e_is_load && (e_rd != '0) &&
                     ((d_rs1_used && (d_rs1 == e_rd)) || (d_rs2_used && (d_rs2 == e_rd)));
  assign mem_stall = dmem_req && !dmem_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_nxt      = state;
    cnt_nxt        = cnt;
    stall_pc       = 1'b0;
    stall_fd       = 1'b0;
    stall_de       = 1'b0;
    flush_fd       = 1'b0;
    flush_de       = 1'b0;
    muldiv_done    = 1'b0;
    loaduse_bubble = 1'b0;

    if (rst) begin
      flush_fd = 1'b1;
      flush_de = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (mem_stall) begin
            {stall_pc, stall_fd, stall_de} = 3'b111;
            state_nxt = MEM_WAIT;
          end else if (e_muldiv_start) begin
            // This cycle is the first of MULDIV_LAT stalled cycles.
            {stall_pc, stall_fd, stall_de} = 3'b111;
            cnt_nxt   = CNT_W'(MULDIV_LAT - 1);
            state_nxt = BUSY;
          end else if (e_redirect) begin
            flush_fd = 1'b1;
            flush_de = 1'b1;
          end else if (load_use) begin
            stall_pc       = 1'b1;
            stall_fd       = 1'b1;
            flush_de       = 1'b1;
            loaduse_bubble = 1'b1;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            {stall_pc, stall_fd, stall_de} = 3'b111;
            cnt_nxt = cnt - 1'b1;
          end else begin
            muldiv_done = 1'b1;
            state_nxt   = IDLE;
          end
        end
        MEM_WAIT: begin
          if (!dmem_ready) begin
            {stall_pc, stall_fd, stall_de} = 3'b111;
          end else begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cycles <= '0;
      perf_flush_cnt    <= '0;
      perf_loaduse_cnt  <= '0;
    end else begin
      perf_stall_cycles <= sat_inc(perf_stall_cycles, stall_pc);
      perf_flush_cnt    <= sat_inc(perf_flush_cnt, flush_fd);
      perf_loaduse_cnt  <= sat_inc(perf_loaduse_cnt, loaduse_bubble);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic against a cycle model.
// Perf-counter checks are compiled in when HAZARD_PERF_EN is defined.
module tb_hazard_ctrl;
  localparam int LAT = 8;
  localparam int AW  = 5;

  // Output vector order: {stall_pc, stall_fd, stall_de, flush_fd, flush_de, muldiv_done}
  localparam logic [5:0] O_NONE  = 6'b000000;
  localparam logic [5:0] O_STALL = 6'b111000;
  localparam logic [5:0] O_LU    = 6'b110010;
  localparam logic [5:0] O_FLUSH = 6'b000110;
  localparam logic [5:0] O_DONE  = 6'b000001;

  logic clk = 1'b0;
  logic rst;
  logic [AW-1:0] d_rs1, d_rs2, e_rd;
  logic d_rs1_used, d_rs2_used, e_is_load, e_muldiv_start, e_redirect, dmem_req, dmem_ready;
  logic stall_pc, stall_fd, stall_de, flush_fd, flush_de, muldiv_done;
  logic [5:0] outs;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cycles, perf_flush_cnt, perf_loaduse_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign outs = {stall_pc, stall_fd, stall_de, flush_fd, flush_de, muldiv_done};

  hazard_ctrl #(.MULDIV_LAT(LAT), .REG_ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .d_rs1(d_rs1), .d_rs2(d_rs2), .d_rs1_used(d_rs1_used), .d_rs2_used(d_rs2_used),
    .e_rd(e_rd), .e_is_load(e_is_load), .e_muldiv_start(e_muldiv_start),
    .e_redirect(e_redirect), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .stall_pc(stall_pc), .stall_fd(stall_fd), .stall_de(stall_de),
    .flush_fd(flush_fd), .flush_de(flush_de), .muldiv_done(muldiv_done)
`ifdef HAZARD_PERF_EN
    , .perf_stall_cycles(perf_stall_cycles), .perf_flush_cnt(perf_flush_cnt),
    .perf_loaduse_cnt(perf_loaduse_cnt)
`endif
  );

  task automatic clear_inputs();
    d_rs1 = '0; d_rs2 = '0; e_rd = '0;
    d_rs1_used = 0; d_rs2_used = 0; e_is_load = 0;
    e_muldiv_start = 0; e_redirect = 0; dmem_req = 0; dmem_ready = 0;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (outs !== O_FLUSH) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got %b expected %b", i, outs, O_FLUSH);
      end
      tick();
    end
    rst = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (outs !== O_NONE) begin
        errors++;
        $display("FAIL reset_release[%0d]: got %b expected %b", i, outs, O_NONE);
      end
      tick();
    end
  endtask

  task automatic test_load_use();
    logic [5:0] exp_v [4];
    exp_v = '{O_LU, O_NONE, O_NONE, O_NONE};
    for (int i = 0; i < 4; i++) begin
      clear_inputs();
      case (i)
        0: begin e_is_load = 1; e_rd = 5; d_rs2 = 5; d_rs2_used = 1; d_rs1 = 3; d_rs1_used = 1; end
        1: begin e_is_load = 0; e_rd = 5; d_rs2 = 5; d_rs2_used = 1; end  // load has left E
        2: begin e_is_load = 1; e_rd = 0; d_rs2 = 0; d_rs2_used = 1; d_rs1 = 0; d_rs1_used = 1; end
        default: begin e_is_load = 1; e_rd = 7; d_rs1 = 7; d_rs1_used = 0; end
      endcase
      @(negedge clk);
      checks++;
      if (outs !== exp_v[i]) begin
        errors++;
        $display("FAIL load_use[%0d]: got %b expected %b", i, outs, exp_v[i]);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_muldiv();
    logic [5:0] e;
    clear_inputs();
    e_muldiv_start = 1;
    for (int i = 0; i <= LAT + 1; i++) begin
      if (i == 2) begin
        e_redirect = 1; e_is_load = 1; e_rd = 4; d_rs1 = 4; d_rs1_used = 1;
      end
      if (i == LAT + 1) e_muldiv_start = 0;
      e = (i < LAT) ? O_STALL : (i == LAT) ? O_DONE : O_NONE;
      if (i == LAT + 1) e = O_FLUSH;  // held redirect now seen in IDLE
      @(negedge clk);
      checks++;
      if (outs !== e) begin
        errors++;
        $display("FAIL muldiv[%0d]: got %b expected %b", i, outs, e);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_mem_wait();
    logic [5:0] e;
    clear_inputs();
    e_muldiv_start = 1;
    dmem_req = 1;
    for (int i = 0; i < 4 + LAT + 1; i++) begin
      dmem_ready = (i == 3);
      if (i > 3) dmem_req = 0;
      if (i < 3)            e = O_STALL;
      else if (i == 3)      e = O_NONE;
      else if (i < 4 + LAT) e = O_STALL;
      else                  e = O_DONE;
      @(negedge clk);
      checks++;
      if (outs !== e) begin
        errors++;
        $display("FAIL mem_wait[%0d]: got %b expected %b", i, outs, e);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_redirect_vs_loaduse();
    clear_inputs();
    e_redirect = 1; e_is_load = 1; e_rd = 9; d_rs1 = 9; d_rs1_used = 1;
    @(negedge clk);
    checks++;
    if (outs !== O_FLUSH) begin
      errors++;
      $display("FAIL redirect_vs_loaduse: got %b expected %b", outs, O_FLUSH);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_reset_busy();
    clear_inputs();
    e_muldiv_start = 1;
    for (int i = 0; i < 4; i++) tick();  // start cycle plus cnt 7,6,5 -> now cnt = 4
    e_muldiv_start = 0;
    rst = 1;
    @(negedge clk);
    checks++;
    if (outs !== O_FLUSH) begin
      errors++;
      $display("FAIL reset_busy_hold: got %b expected %b", outs, O_FLUSH);
    end
    tick();
    rst = 0;
    for (int i = 0; i < LAT + 2; i++) begin
      @(negedge clk);
      checks++;
      if (outs !== O_NONE) begin
        errors++;
        $display("FAIL reset_busy_after[%0d]: got %b expected %b", i, outs, O_NONE);
      end
`ifdef HAZARD_PERF_EN
      if (i == 0) begin
        checks++;
        if ({perf_stall_cycles, perf_flush_cnt, perf_loaduse_cnt} !== 96'd0) begin
          errors++;
          $display("FAIL perf_after_reset: got %0d/%0d/%0d expected 0/0/0",
                   perf_stall_cycles, perf_flush_cnt, perf_loaduse_cnt);
        end
      end
`endif
      tick();
    end
  endtask

  // Reference model: tracks how many mul/div stall cycles have elapsed and whether a
  // memory access is outstanding, then applies the priority rules directly.
  task automatic test_random();
    bit in_mem_wait = 0;
    int mul_age = -1;
    int n_stall = 0, n_flush = 0, n_lu = 0;
    logic [5:0] e;
    bit lu;
    for (int i = 0; i < 3000; i++) begin
      rst            = (i == 0) || ($urandom_range(63) == 0);
      e_rd           = AW'($urandom_range(3));
      d_rs1          = AW'($urandom_range(3));
      d_rs2          = AW'($urandom_range(3));
      d_rs1_used     = $urandom_range(1);
      d_rs2_used     = $urandom_range(1);
      e_is_load      = $urandom_range(1);
      e_muldiv_start = ($urandom_range(7) == 0);
      e_redirect     = ($urandom_range(5) == 0);
      dmem_req       = ($urandom_range(3) == 0);
      dmem_ready     = $urandom_range(1);
      lu = e_is_load && (e_rd != 0) &&
           ((d_rs1_used && d_rs1 == e_rd) || (d_rs2_used && d_rs2 == e_rd));

      e = O_NONE;
      if (rst) begin
        e = O_FLUSH; in_mem_wait = 0; mul_age = -1;
      end else if (mul_age >= 0) begin
        if (mul_age < LAT) begin e = O_STALL; mul_age++; end
        else begin e = O_DONE; mul_age = -1; end
      end else if (in_mem_wait) begin
        if (dmem_ready) in_mem_wait = 0;
        else e = O_STALL;
      end else if (dmem_req && !dmem_ready) begin
        e = O_STALL; in_mem_wait = 1;
      end else if (e_muldiv_start) begin
        e = O_STALL; mul_age = 1;
      end else if (e_redirect) begin
        e = O_FLUSH;
      end else if (lu) begin
        e = O_LU; n_lu++;
      end

      if (rst) begin
        n_stall = 0; n_flush = 0; n_lu = 0;
      end else begin
        if (e[5]) n_stall++;
        if (e[2]) n_flush++;
      end

      @(negedge clk);
      checks++;
      if (outs !== e) begin
        errors++;
        $display("FAIL random[%0d]: got %b expected %b", i, outs, e);
      end
      tick();
    end
    rst = 0;
    clear_inputs();
`ifdef HAZARD_PERF_EN
    checks++;
    if (perf_stall_cycles !== 32'(n_stall) || perf_flush_cnt !== 32'(n_flush) ||
        perf_loaduse_cnt !== 32'(n_lu)) begin
      errors++;
      $display("FAIL perf_random: got %0d/%0d/%0d expected %0d/%0d/%0d",
               perf_stall_cycles, perf_flush_cnt, perf_loaduse_cnt, n_stall, n_flush, n_lu);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_muldiv();
    test_mem_wait();
    test_redirect_vs_loaduse();
    test_reset_busy();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
